// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared state encoding and defaults for the MEM stage
package mem_stage_pkg;

  localparam int ARQ_DEF     = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - BUSY-cycle watchdog, compiled only with MEM_TIMEOUT_EN
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of completed BUSY cycles, so TIMEOUT-1 marks the TIMEOUT-th one
  assign expire = run && (cnt == W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline MEM stage with req/ack data memory port
// Optional access watchdog and sticky err_out enabled by MEM_TIMEOUT_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ARQ     = ARQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_enable_in,
  input  logic           mem_enable_in,
  input  logic           mem_write_in,
  input  logic [ARQ-1:0] src1_in,
  input  logic [ARQ-1:0] srcdest_in,
  input  logic [ARQ-1:0] alu_result_in,
  output logic           mem_req,
  output logic           mem_we,
  output logic [ARQ-1:0] mem_addr,
  output logic [ARQ-1:0] mem_wdata,
  input  logic           mem_ack,
  input  logic [ARQ-1:0] mem_rdata,
  output logic           stall_out,
  output logic           wb_enable_out,
  output logic [ARQ-1:0] wb_data_out,
  output logic [ARQ-1:0] srcdest_out,
  output logic           err_out
);

  state_t         state;
  logic [ARQ-1:0] addr_q;
  logic [ARQ-1:0] wdata_q;
  logic [ARQ-1:0] srcdest_q;
  logic           we_q;
  logic           wbe_q;
  logic           busy;
  logic           timeout_hit;

  assign busy = (state == BUSY);

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (~busy),
    .run    (busy & ~mem_ack),
    .expire (timeout_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_out <= 1'b0;
    end else if (timeout_hit) begin
      err_out <= 1'b1;
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
  assign err_out        = 1'b0;
`endif

  // mem_req follows the state register, so an async reset drops it immediately
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign stall_out = (~busy & mem_enable_in) | (busy & ~mem_ack & ~timeout_hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      srcdest_q     <= '0;
      we_q          <= 1'b0;
      wbe_q         <= 1'b0;
      wb_enable_out <= 1'b0;
      wb_data_out   <= '0;
      srcdest_out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_enable_in) begin
            addr_q        <= alu_result_in;
            wdata_q       <= src1_in;
            srcdest_q     <= srcdest_in;
            we_q          <= mem_write_in;
            wbe_q         <= wb_enable_in & ~mem_write_in;
            wb_enable_out <= 1'b0;
            state         <= BUSY;
          end else begin
            wb_enable_out <= wb_enable_in;
            wb_data_out   <= alu_result_in;
            srcdest_out   <= srcdest_in;
          end
        end
        BUSY: begin
          wb_enable_out <= 1'b0;
          if (mem_ack) begin
            state       <= IDLE;
            srcdest_out <= srcdest_q;
            if (we_q) begin
              wb_data_out <= addr_q;
            end else begin
              wb_data_out   <= mem_rdata;
              wb_enable_out <= wbe_q;
            end
          end else if (timeout_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
